axil_xbar_1xn: RTL and testbench
================================

AXIL_XBAR_1XN -- requirements
Module: axil_xbar_1xn

Interface
REQ-001 The module SHALL be a parametrised 1-master to NSLV-slave AXI-lite crossbar with independent read and write paths.
REQ-002 ADDR_W, default 32, address width.
REQ-003 DATA_W, default 32, data width (multiple of 8); strobe width SHALL be DATA_W/8.
REQ-004 NSLV, default 2, slave count (1..8); SEL_W = max(1, clog2(NSLV)).
REQ-005 SLV_BASE, default {32'hA000_0000, 32'h8000_0000}, packed NSLV*ADDR_W base addresses, slave 0 in LSBs.
REQ-006 SLV_MASK, default {32'hFF00_0000, 32'hF800_0000}, packed NSLV*ADDR_W decode masks.
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 up_araddr/up_arvalid/up_arready  in/in/out  ADDR_W/1/1  master read-address channel.
REQ-010 up_rdata/up_rresp/up_rvalid/up_rready  out/out/out/in  DATA_W/2/1/1  master read-data channel.
REQ-011 up_awaddr/up_awvalid/up_awready  in/in/out  ADDR_W/1/1  master write-address channel.
REQ-012 up_wdata/up_wstrb/up_wvalid/up_wready  in/in/in/out  DATA_W/DATA_W/8/1/1  master write-data channel.
REQ-013 up_bresp/up_bvalid/up_bready  out/out/in  2/1/1  master write-response channel.
REQ-014 dn_araddr/dn_arvalid/dn_arready  out/out/in  ADDR_W/NSLV/NSLV  slave read-address; address broadcast, valid/ready one bit per slave.
REQ-015 dn_rdata/dn_rresp/dn_rvalid/dn_rready  in/in/in/out  NSLV*DATA_W/NSLV*2/NSLV/NSLV  slave read-data, packed per slave.
REQ-016 dn_awaddr, dn_wdata, dn_wstrb (broadcast, out); dn_awvalid, dn_wvalid, dn_bready (out, NSLV); dn_awready, dn_wready, dn_bvalid (in, NSLV); dn_bresp (in, NSLV*2)  slave write channels.

Function
REQ-017 Decode: slave i SHALL be hit when (addr & SLV_MASK[i]) == SLV_BASE[i]; lowest index SHALL win on overlap; no hit is a decode miss.
REQ-018 Read FSM states R_IDLE, R_AR, R_R, R_RESP; up_arready SHALL be 1 only in R_IDLE.
REQ-019 On the AR handshake, the block SHALL latch address and slave index and go to R_AR on a hit, or to R_RESP with rdata=0, rresp=2'b11 on a miss.
REQ-020 R_AR SHALL assert dn_arvalid[sel] only, holding until dn_arready[sel], then go to R_R; R_R SHALL assert dn_rready[sel] and latch rdata/rresp on handshake, then go to R_RESP.
REQ-021 R_RESP SHALL hold up_rvalid=1 with stable data until up_rready, then go to R_IDLE.
REQ-022 Latency with zero-wait slave and master: up_rvalid SHALL rise 3 cycles after the AR handshake edge on a hit and 1 cycle after on a miss.
REQ-023 Write FSM states W_IDLE, W_REQ, W_B, W_RESP. In W_IDLE, up_awready SHALL be 1 until AW is captured and up_wready SHALL be 1 until W is captured; both may be captured in the same cycle or in either order.
REQ-024 Once both AW and W are captured, the FSM SHALL go to W_REQ on a hit, or to W_RESP with bresp=2'b11 and no downstream access on a miss.
REQ-025 W_REQ SHALL assert dn_awvalid[sel] and dn_wvalid[sel] together, drop each independently on its own handshake, and go to W_B when both are done, including a same-cycle finish.
REQ-026 W_B SHALL assert dn_bready[sel] and latch bresp on handshake; W_RESP SHALL hold up_bvalid until up_bready, then go to W_IDLE.
REQ-027 Read and write FSMs SHALL be independent and may target the same slave concurrently.
REQ-028 All valid/ready outputs SHALL decode from state registers; there SHALL be no combinational path from any input to any output.
REQ-029 Non-selected slaves SHALL see all valid/ready bits at 0.

Reset
REQ-030 While rst_n=0: all FSMs in idle; every output 0, including up_arready, up_awready and up_wready; latched address/data/resp registers 0.
REQ-031 Reset asserted mid-transaction SHALL abort it immediately; the first cycle after deassertion SHALL show idle readiness.

Configuration
REQ-032 AXIL_XBAR_PERF_EN defined: the block SHALL add 32-bit outputs perf_rd_cnt (+1 per up R handshake), perf_wr_cnt (+1 per up B handshake) and perf_err_cnt (+1 per delivered resp of 2'b10 or 2'b11), each wrapping at 2^32 and reset to 0.
REQ-033 AXIL_XBAR_PERF_EN undefined: the counter ports and logic SHALL be absent, with all other behaviour unchanged.

Verification
REQ-034 Read 0x8000_0010, slave0 returns 32'hDEAD_BEEF/OKAY with zero wait -> up_rdata=32'hDEAD_BEEF, rresp=0, rvalid exactly 3 cycles after AR handshake; dn_arvalid[1] never set.
REQ-035 Read 0x1234_0000 (miss) -> no dn_arvalid; up_rresp=2'b11, rdata=0, one cycle after handshake.
REQ-036 W before AW by 2 cycles, addr 0xA000_0004, wdata 32'h55AA, wstrb 4'b0011 -> slave1 receives exactly that; dn_awready delayed 3 cycles, dn_wready immediate -> dn_wvalid[1] drops first, up_bresp=slave bresp.
REQ-037 Concurrent read slave0 and write slave1, up_rready/up_bready held low 5 cycles -> both responses held stable, no second up_arready until rready.
REQ-038 rst_n pulled low in R_R -> all outputs 0 asynchronously; after release, up_arready=1 next cycle.
REQ-039 AXIL_XBAR_PERF_EN: 3 reads, 2 writes, 1 miss -> perf_rd_cnt=3, perf_wr_cnt=2, perf_err_cnt=1.

Source files
------------

// File: rtl/axil_xbar_1xn.sv
// One-master to NSLV-slave AXI-lite crossbar with independent read and write FSMs.
// Define AXIL_XBAR_PERF_EN to add the perf_rd_cnt/perf_wr_cnt/perf_err_cnt counter ports.
module axil_xbar_1xn #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 2,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = {32'hA000_0000, 32'h8000_0000},
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = {32'hFF00_0000, 32'hF800_0000}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      up_araddr,
  input  logic                   up_arvalid,
  output logic                   up_arready,
  output logic [DATA_W-1:0]      up_rdata,
  output logic [1:0]             up_rresp,
  output logic                   up_rvalid,
  input  logic                   up_rready,
  input  logic [ADDR_W-1:0]      up_awaddr,
  input  logic                   up_awvalid,
  output logic                   up_awready,
  input  logic [DATA_W-1:0]      up_wdata,
  input  logic [DATA_W/8-1:0]    up_wstrb,
  input  logic                   up_wvalid,
  output logic                   up_wready,
  output logic [1:0]             up_bresp,
  output logic                   up_bvalid,
  input  logic                   up_bready,
  output logic [ADDR_W-1:0]      dn_araddr,
  output logic [NSLV-1:0]        dn_arvalid,
  input  logic [NSLV-1:0]        dn_arready,
  input  logic [NSLV*DATA_W-1:0] dn_rdata,
  input  logic [NSLV*2-1:0]      dn_rresp,
  input  logic [NSLV-1:0]        dn_rvalid,
  output logic [NSLV-1:0]        dn_rready,
  output logic [ADDR_W-1:0]      dn_awaddr,
  output logic [NSLV-1:0]        dn_awvalid,
  input  logic [NSLV-1:0]        dn_awready,
  output logic [DATA_W-1:0]      dn_wdata,
  output logic [DATA_W/8-1:0]    dn_wstrb,
  output logic [NSLV-1:0]        dn_wvalid,
  input  logic [NSLV-1:0]        dn_wready,
  input  logic [NSLV*2-1:0]      dn_bresp,
  input  logic [NSLV-1:0]        dn_bvalid,
  output logic [NSLV-1:0]        dn_bready
`ifdef AXIL_XBAR_PERF_EN
  ,
  output logic [31:0]            perf_rd_cnt,
  output logic [31:0]            perf_wr_cnt,
  output logic [31:0]            perf_err_cnt
`endif
);

  localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_R    = 2'd2;
  localparam logic [1:0] R_RESP = 2'd3;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_B    = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  // Returns {hit, index}; scanning downward lets the lowest matching slave win.
  function automatic logic [SEL_W:0] decode(input logic [ADDR_W-1:0] addr);
    logic [SEL_W:0] res;
    res = {(SEL_W+1){1'b0}};
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        res = {1'b1, SEL_W'(i)};
      end
    end
    return res;
  endfunction

  logic [1:0]       rstate;
  logic [1:0]       wstate;
  logic [SEL_W-1:0] rsel;
  logic [SEL_W-1:0] wsel;
  logic             ready_en;
  logic             aw_got;
  logic             w_got;
  logic             aw_pend;
  logic             w_pend;
  logic             aw_hs;
  logic             w_hs;
  logic [ADDR_W-1:0] aw_addr_eff;
  logic [SEL_W:0]   ar_dec;
  logic [SEL_W:0]   aw_dec;

  assign aw_hs       = up_awvalid && up_awready;
  assign w_hs        = up_wvalid && up_wready;
  assign aw_addr_eff = aw_hs ? up_awaddr : dn_awaddr;
  assign ar_dec      = decode(up_araddr);
  assign aw_dec      = decode(aw_addr_eff);

  // Readiness is held off until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Read FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate    <= R_IDLE;
      rsel      <= {SEL_W{1'b0}};
      dn_araddr <= {ADDR_W{1'b0}};
      up_rdata  <= {DATA_W{1'b0}};
      up_rresp  <= 2'b00;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (up_arvalid && up_arready) begin
            dn_araddr <= up_araddr;
            if (ar_dec[SEL_W]) begin
              rsel   <= ar_dec[SEL_W-1:0];
              rstate <= R_AR;
            end else begin
              up_rdata <= {DATA_W{1'b0}};
              up_rresp <= 2'b11;
              rstate   <= R_RESP;
            end
          end
        end
        R_AR: begin
          if (dn_arready[rsel]) begin
            rstate <= R_R;
          end
        end
        R_R: begin
          if (dn_rvalid[rsel]) begin
            up_rdata <= dn_rdata[rsel*DATA_W +: DATA_W];
            up_rresp <= dn_rresp[rsel*2 +: 2];
            rstate   <= R_RESP;
          end
        end
        R_RESP: begin
          if (up_rready) begin
            rstate <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Write FSM; AW and W may arrive in any order before the downstream request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate    <= W_IDLE;
      wsel      <= {SEL_W{1'b0}};
      dn_awaddr <= {ADDR_W{1'b0}};
      dn_wdata  <= {DATA_W{1'b0}};
      dn_wstrb  <= {(DATA_W/8){1'b0}};
      up_bresp  <= 2'b00;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            dn_awaddr <= up_awaddr;
          end
          if (w_hs) begin
            dn_wdata <= up_wdata;
            dn_wstrb <= up_wstrb;
          end
          if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            if (aw_dec[SEL_W]) begin
              wsel    <= aw_dec[SEL_W-1:0];
              aw_pend <= 1'b1;
              w_pend  <= 1'b1;
              wstate  <= W_REQ;
            end else begin
              up_bresp <= 2'b11;
              wstate   <= W_RESP;
            end
          end else begin
            if (aw_hs) aw_got <= 1'b1;
            if (w_hs)  w_got  <= 1'b1;
          end
        end
        W_REQ: begin
          if (dn_awready[wsel]) aw_pend <= 1'b0;
          if (dn_wready[wsel])  w_pend  <= 1'b0;
          if ((!aw_pend || dn_awready[wsel]) && (!w_pend || dn_wready[wsel])) begin
            wstate <= W_B;
          end
        end
        W_B: begin
          if (dn_bvalid[wsel]) begin
            up_bresp <= dn_bresp[wsel*2 +: 2];
            wstate   <= W_RESP;
          end
        end
        W_RESP: begin
          if (up_bready) begin
            wstate <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  assign up_arready = ready_en && (rstate == R_IDLE);
  assign up_rvalid  = (rstate == R_RESP);
  assign up_awready = ready_en && (wstate == W_IDLE) && !aw_got;
  assign up_wready  = ready_en && (wstate == W_IDLE) && !w_got;
  assign up_bvalid  = (wstate == W_RESP);

  // Per-slave handshake strobes, only the selected slave ever sees a 1.
  always_comb begin
    dn_arvalid = {NSLV{1'b0}};
    dn_rready  = {NSLV{1'b0}};
    dn_awvalid = {NSLV{1'b0}};
    dn_wvalid  = {NSLV{1'b0}};
    dn_bready  = {NSLV{1'b0}};
    for (int i = 0; i < NSLV; i++) begin
      dn_arvalid[i] = (rstate == R_AR) && (rsel == SEL_W'(i));
      dn_rready[i]  = (rstate == R_R)  && (rsel == SEL_W'(i));
      dn_awvalid[i] = (wstate == W_REQ) && aw_pend && (wsel == SEL_W'(i));
      dn_wvalid[i]  = (wstate == W_REQ) && w_pend  && (wsel == SEL_W'(i));
      dn_bready[i]  = (wstate == W_B)  && (wsel == SEL_W'(i));
    end
  end

`ifdef AXIL_XBAR_PERF_EN
  logic        rd_done;
  logic        wr_done;
  logic [31:0] err_inc;

  assign rd_done = up_rvalid && up_rready;
  assign wr_done = up_bvalid && up_bready;
  // A read and a write error can be delivered in the same cycle.
  assign err_inc = {31'd0, rd_done && up_rresp[1]} + {31'd0, wr_done && up_bresp[1]};

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_cnt  <= 32'd0;
      perf_wr_cnt  <= 32'd0;
      perf_err_cnt <= 32'd0;
    end else begin
      if (rd_done) perf_rd_cnt <= perf_rd_cnt + 32'd1;
      if (wr_done) perf_wr_cnt <= perf_wr_cnt + 32'd1;
      perf_err_cnt <= perf_err_cnt + err_inc;
    end
  end
`endif

endmodule

// File: tb/tb_axil_xbar_1xn.sv
// Directed bench for axil_xbar_1xn: two behavioural slaves, hand-computed expectations.
module tb_axil_xbar_1xn;

  logic        clk;
  logic        rst_n;
  logic [31:0] up_araddr;
  logic        up_arvalid;
  logic        up_arready;
  logic [31:0] up_rdata;
  logic [1:0]  up_rresp;
  logic        up_rvalid;
  logic        up_rready;
  logic [31:0] up_awaddr;
  logic        up_awvalid;
  logic        up_awready;
  logic [31:0] up_wdata;
  logic [3:0]  up_wstrb;
  logic        up_wvalid;
  logic        up_wready;
  logic [1:0]  up_bresp;
  logic        up_bvalid;
  logic        up_bready;
  logic [31:0] dn_araddr;
  logic [1:0]  dn_arvalid;
  logic [1:0]  dn_arready;
  logic [63:0] dn_rdata;
  logic [3:0]  dn_rresp;
  logic [1:0]  dn_rvalid;
  logic [1:0]  dn_rready;
  logic [31:0] dn_awaddr;
  logic [1:0]  dn_awvalid;
  logic [1:0]  dn_awready;
  logic [31:0] dn_wdata;
  logic [3:0]  dn_wstrb;
  logic [1:0]  dn_wvalid;
  logic [1:0]  dn_wready;
  logic [3:0]  dn_bresp;
  logic [1:0]  dn_bvalid;
  logic [1:0]  dn_bready;
`ifdef AXIL_XBAR_PERF_EN
  logic [31:0] perf_rd_cnt;
  logic [31:0] perf_wr_cnt;
  logic [31:0] perf_err_cnt;
`endif

  int total = 0;
  int bad = 0;

  // Slave behaviour knobs, set by the stimulus
  logic [31:0] slv_rdata [2];
  logic [1:0]  slv_rresp [2];
  logic [1:0]  slv_bresp [2];
  int          aw_delay  [2];
  logic [1:0]  rd_hold;

  // Slave state and observation
  logic [1:0]  rv = 2'b00;
  logic [1:0]  bv = 2'b00;
  logic [1:0]  aw_done = 2'b00;
  logic [1:0]  w_done = 2'b00;
  int          aw_cnt [2];
  logic [31:0] got_awaddr [2];
  logic [31:0] got_wdata [2];
  logic [3:0]  got_wstrb [2];
  int          arv_cnt [2];
  int          awv_cnt [2];
  int          wv_cnt [2];
  int          aw_only_cnt [2];

  axil_xbar_1xn dut (
    .clk(clk), .rst_n(rst_n),
    .up_araddr(up_araddr), .up_arvalid(up_arvalid), .up_arready(up_arready),
    .up_rdata(up_rdata), .up_rresp(up_rresp), .up_rvalid(up_rvalid), .up_rready(up_rready),
    .up_awaddr(up_awaddr), .up_awvalid(up_awvalid), .up_awready(up_awready),
    .up_wdata(up_wdata), .up_wstrb(up_wstrb), .up_wvalid(up_wvalid), .up_wready(up_wready),
    .up_bresp(up_bresp), .up_bvalid(up_bvalid), .up_bready(up_bready),
    .dn_araddr(dn_araddr), .dn_arvalid(dn_arvalid), .dn_arready(dn_arready),
    .dn_rdata(dn_rdata), .dn_rresp(dn_rresp), .dn_rvalid(dn_rvalid), .dn_rready(dn_rready),
    .dn_awaddr(dn_awaddr), .dn_awvalid(dn_awvalid), .dn_awready(dn_awready),
    .dn_wdata(dn_wdata), .dn_wstrb(dn_wstrb), .dn_wvalid(dn_wvalid), .dn_wready(dn_wready),
    .dn_bresp(dn_bresp), .dn_bvalid(dn_bvalid), .dn_bready(dn_bready)
`ifdef AXIL_XBAR_PERF_EN
    ,
    .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_err_cnt(perf_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dn_arready = 2'b11;
  assign dn_wready  = 2'b11;
  assign dn_rvalid  = rv;
  assign dn_bvalid  = bv;
  assign dn_rdata   = {slv_rdata[1], slv_rdata[0]};
  assign dn_rresp   = {slv_rresp[1], slv_rresp[0]};
  assign dn_bresp   = {slv_bresp[1], slv_bresp[0]};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dn_awready[i] = dn_awvalid[i] && (aw_cnt[i] >= aw_delay[i]);
    end
  end

  // Behavioural slaves plus per-slave activity counters.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      arv_cnt[i]     <= arv_cnt[i] + (dn_arvalid[i] ? 1 : 0);
      awv_cnt[i]     <= awv_cnt[i] + (dn_awvalid[i] ? 1 : 0);
      wv_cnt[i]      <= wv_cnt[i] + (dn_wvalid[i] ? 1 : 0);
      aw_only_cnt[i] <= aw_only_cnt[i] + ((dn_awvalid[i] && !dn_wvalid[i]) ? 1 : 0);
      if (dn_arvalid[i] && dn_arready[i] && !rd_hold[i]) rv[i] <= 1'b1;
      else if (rv[i] && dn_rready[i]) rv[i] <= 1'b0;
      if (dn_awvalid[i] && dn_awready[i]) begin
        got_awaddr[i] <= dn_awaddr;
        aw_cnt[i] <= 0;
      end else if (dn_awvalid[i]) begin
        aw_cnt[i] <= aw_cnt[i] + 1;
      end
      if (dn_wvalid[i] && dn_wready[i]) begin
        got_wdata[i] <= dn_wdata;
        got_wstrb[i] <= dn_wstrb;
      end
      if (bv[i] && dn_bready[i]) bv[i] <= 1'b0;
      if ((aw_done[i] || (dn_awvalid[i] && dn_awready[i])) &&
          (w_done[i] || (dn_wvalid[i] && dn_wready[i]))) begin
        bv[i] <= 1'b1;
        aw_done[i] <= 1'b0;
        w_done[i] <= 1'b0;
      end else begin
        if (dn_awvalid[i] && dn_awready[i]) aw_done[i] <= 1'b1;
        if (dn_wvalid[i] && dn_wready[i]) w_done[i] <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one read from a negedge with up_rready high; returns cycles to up_rvalid.
  task automatic do_read(input logic [31:0] addr, output int lat,
                         output logic [31:0] data, output logic [1:0] resp);
    int k;
    up_araddr = addr;
    up_arvalid = 1'b1;
    k = 0;
    while (!up_arready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    @(negedge clk);
    up_arvalid = 1'b0;
    lat = 1;
    while (!up_rvalid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    data = up_rdata;
    resp = up_rresp;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue AW and W together from a negedge with up_bready high.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic seen, output logic [1:0] resp);
    int k;
    up_awaddr = addr;
    up_wdata = data;
    up_wstrb = strb;
    up_awvalid = 1'b1;
    up_wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    up_awvalid = 1'b0;
    up_wvalid = 1'b0;
    k = 0;
    while (!up_bvalid && k < 30) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    seen = up_bvalid;
    resp = up_bresp;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int k;
    int s0;
    int s1;
    int s2;
    int s3;
    logic [31:0] d;
    logic [1:0] r;
    logic seen;

    rst_n = 1'b0;
    up_araddr = 32'h0; up_arvalid = 1'b0; up_rready = 1'b0;
    up_awaddr = 32'h0; up_awvalid = 1'b0; up_wdata = 32'h0; up_wstrb = 4'h0;
    up_wvalid = 1'b0; up_bready = 1'b0;
    slv_rdata[0] = 32'h0; slv_rdata[1] = 32'h0;
    slv_rresp[0] = 2'b00; slv_rresp[1] = 2'b00;
    slv_bresp[0] = 2'b00; slv_bresp[1] = 2'b00;
    aw_delay[0] = 0; aw_delay[1] = 0;
    rd_hold = 2'b00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_arready", up_arready, 1'b0);
    chk("rst_awready", up_awready, 1'b0);
    chk("rst_wready", up_wready, 1'b0);
    chk("rst_rvalid", up_rvalid, 1'b0);
    chk("rst_bvalid", up_bvalid, 1'b0);
    chk("rst_dn_valids", {dn_arvalid, dn_awvalid, dn_wvalid, dn_rready, dn_bready}, 10'h0);
    chk("rst_rdata", up_rdata, 32'h0);
    rst_n = 1'b1;
    up_rready = 1'b1;
    up_bready = 1'b1;
    @(negedge clk);
    chk("idle_arready", up_arready, 1'b1);
    chk("idle_awready", up_awready, 1'b1);
    chk("idle_wready", up_wready, 1'b1);

    // Hit read on slave 0
    slv_rdata[0] = 32'hDEAD_BEEF;
    s0 = arv_cnt[0]; s1 = arv_cnt[1];
    do_read(32'h8000_0010, lat, d, r);
    chk("a_lat", lat, 3);
    chk("a_rdata", d, 32'hDEAD_BEEF);
    chk("a_rresp", r, 2'b00);
    chk("a_arv0", arv_cnt[0] - s0, 1);
    chk("a_arv1", arv_cnt[1] - s1, 0);
    chk("a_rvalid_clr", up_rvalid, 1'b0);

    // Read decode miss
    s0 = arv_cnt[0]; s1 = arv_cnt[1];
    do_read(32'h1234_0000, lat, d, r);
    chk("b_lat", lat, 1);
    chk("b_rdata", d, 32'h0);
    chk("b_rresp", r, 2'b11);
    chk("b_arv", (arv_cnt[0] - s0) + (arv_cnt[1] - s1), 0);

    // Write decode miss
    s0 = awv_cnt[0] + wv_cnt[0]; s1 = awv_cnt[1] + wv_cnt[1];
    do_write(32'h4000_0000, 32'h1, 4'hF, seen, r);
    chk("bw_seen", seen, 1'b1);
    chk("bw_bresp", r, 2'b11);
    chk("bw_dn", (awv_cnt[0] + wv_cnt[0] - s0) + (awv_cnt[1] + wv_cnt[1] - s1), 0);

    // W leads AW by two cycles; slave 1 holds AW ready off for three cycles
    slv_bresp[1] = 2'b01;
    aw_delay[1] = 3;
    s0 = awv_cnt[0]; s1 = awv_cnt[1]; s2 = wv_cnt[1]; s3 = aw_only_cnt[1];
    up_wdata = 32'h0000_55AA; up_wstrb = 4'b0011; up_wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    up_wvalid = 1'b0;
    chk("c_wready_low", up_wready, 1'b0);
    chk("c_awready_hi", up_awready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    up_awaddr = 32'hA000_0004; up_awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    up_awvalid = 1'b0;
    k = 0;
    while (!up_bvalid && k < 30) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    chk("c_bvalid", up_bvalid, 1'b1);
    chk("c_bresp", up_bresp, 2'b01);
    chk("c_awaddr", got_awaddr[1], 32'hA000_0004);
    chk("c_wdata", got_wdata[1], 32'h0000_55AA);
    chk("c_wstrb", got_wstrb[1], 4'b0011);
    chk("c_awv1", awv_cnt[1] - s1, 4);
    chk("c_wv1", wv_cnt[1] - s2, 1);
    chk("c_aw_only", aw_only_cnt[1] - s3, 3);
    chk("c_awv0", awv_cnt[0] - s0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("c_bvalid_clr", up_bvalid, 1'b0);

    // Concurrent read slave 0 / write slave 1 with both responses back-pressured
    slv_rdata[0] = 32'h1111_2222;
    slv_bresp[1] = 2'b00;
    aw_delay[1] = 0;
    up_rready = 1'b0; up_bready = 1'b0;
    up_araddr = 32'h8000_0020; up_arvalid = 1'b1;
    up_awaddr = 32'hA000_0008; up_awvalid = 1'b1;
    up_wdata = 32'h0000_BEEF; up_wstrb = 4'hF; up_wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    up_arvalid = 1'b0; up_awvalid = 1'b0; up_wvalid = 1'b0;
    k = 0;
    while (!(up_rvalid && up_bvalid) && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    for (int c = 0; c < 5; c++) begin
      chk("d_rvalid", up_rvalid, 1'b1);
      chk("d_rdata", up_rdata, 32'h1111_2222);
      chk("d_bvalid", up_bvalid, 1'b1);
      chk("d_bresp", up_bresp, 2'b00);
      chk("d_arready", up_arready, 1'b0);
      chk("d_awready", up_awready, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("d_wdata", got_wdata[1], 32'h0000_BEEF);
    chk("d_awaddr", got_awaddr[1], 32'hA000_0008);
    up_rready = 1'b1; up_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("d_rvalid_clr", up_rvalid, 1'b0);
    chk("d_bvalid_clr", up_bvalid, 1'b0);
    chk("d_arready_back", up_arready, 1'b1);

    // Asynchronous reset while the read waits in R_R
    rd_hold[0] = 1'b1;
    up_araddr = 32'h8000_0000; up_arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    up_arvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("e_rready_in_rr", dn_rready, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("e_rst_rready", dn_rready, 2'b00);
    chk("e_rst_arready", up_arready, 1'b0);
    chk("e_rst_wready", up_wready, 1'b0);
    chk("e_rst_rdata", up_rdata, 32'h0);
    chk("e_rst_araddr", dn_araddr, 32'h0);
    chk("e_rst_awaddr", dn_awaddr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_hold[0] = 1'b0;
    @(negedge clk);
    chk("e_arready_after", up_arready, 1'b1);
    chk("e_awready_after", up_awready, 1'b1);

    // Mixed traffic after reset: 2 hit reads, 1 miss read, 2 OK writes
    slv_rdata[0] = 32'h0BAD_F00D;
    slv_rdata[1] = 32'hCAFE_F00D;
    do_read(32'h8000_0040, lat, d, r);
    chk("f_rd0", d, 32'h0BAD_F00D);
    do_read(32'hA000_0100, lat, d, r);
    chk("f_rd1", d, 32'hCAFE_F00D);
    chk("f_lat1", lat, 3);
    do_read(32'h0000_0000, lat, d, r);
    chk("f_miss", r, 2'b11);
    do_write(32'h8000_0004, 32'h1234_5678, 4'b1100, seen, r);
    chk("f_wr0_resp", {seen, r}, 3'b100);
    chk("f_wr0_data", {got_wstrb[0], got_wdata[0]}, {4'b1100, 32'h1234_5678});
    do_write(32'hA000_0010, 32'h8765_4321, 4'hF, seen, r);
    chk("f_wr1_resp", {seen, r}, 3'b100);
    chk("f_wr1_addr", got_awaddr[1], 32'hA000_0010);
`ifdef AXIL_XBAR_PERF_EN
    chk("f_perf_rd", perf_rd_cnt, 32'd3);
    chk("f_perf_wr", perf_wr_cnt, 32'd2);
    chk("f_perf_err", perf_err_cnt, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
